pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It handles three cases: load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory accesses using a ready handshake with a timeout. It sits beside the stage registers and replaces their free-running clocking with gated enables.

Parameters:
REG_W, 5, register-specifier width
MEM_TIMEOUT, 16, max cycles spent in MEM_WAIT before the error trap (>=2)
CNT_W, 16, width of the stall performance counter

Ports:
Clk  input  1  pipeline clock, rising edge
Rst_n  input  1  reset, asynchronous, active-low
IdRs  input  REG_W  rs of instruction in IF/ID
IdRt  input  REG_W  rt of instruction in IF/ID
IdUsesRt  input  1  instruction in IF/ID reads rt
ExMemRead  input  1  ID/EX MemRead (load in EX)
ExRt  input  REG_W  destination rt of instruction in EX
MemBranch  input  1  EX/MEM Branch
MemZero  input  1  EX/MEM zero flag
MemMemRead  input  1  EX/MEM MemRead
MemMemWrite  input  1  EX/MEM MemWrite
MemReady  input  1  data memory acknowledges current access
PCWrite  output  1  PC load enable
PCSrc  output  1  select branch target
IFIDWrite  output  1  IF/ID enable
IFIDFlush  output  1  IF/ID clear to NOP
IDEXWrite  output  1  ID/EX enable
IDEXFlush  output  1  ID/EX clear to bubble
EXMEMWrite  output  1  EX/MEM enable
EXMEMFlush  output  1  EX/MEM clear to bubble
MEMWBFlush  output  1  MEM/WB load bubble
MemReq  output  1  data-memory request strobe
MemTimeout  output  1  sticky error flag
StallCount  output  CNT_W  saturating count of cycles with PCWrite=0

Behaviour:
- Registered state: St in {RUN, MEM_WAIT, ERROR}, WaitCnt, MemTimeout, StallCount. All other outputs are combinational decodes of St and the inputs.
- Reset (Rst_n=0, asynchronous):
  - St=RUN, WaitCnt=0, MemTimeout=0, StallCount=0.
  - While Rst_n=0: every *Write=0, every *Flush=1, PCSrc=0, MemReq=0.
- Default in RUN with no event: every *Write=1, every *Flush=0, PCSrc=0.
- Access = MemMemRead | MemMemWrite. Taken = MemBranch & MemZero. LoadUse = ExMemRead & (ExRt!=0) & ((ExRt==IdRs) | (IdUsesRt & ExRt==IdRt)).
- Priority, highest first: ERROR > memory stall > taken branch > load-use.
- RUN, Access=1:
  - MemReq=1.
  - If MemReady=1 in the same cycle: no stall; evaluate the lower-priority events normally.
  - Otherwise: PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=0, MEMWBFlush=1. Next St=MEM_WAIT, WaitCnt<=1.
- MEM_WAIT:
  - MemReq=1 held; same freeze as above.
  - MemReady=1: release. This cycle behaves as RUN with the access complete: MEMWBFlush=0, all enables 1, and Taken/LoadUse are evaluated this cycle. Next St=RUN, WaitCnt<=0.
  - MemReady=0 and WaitCnt==MEM_TIMEOUT-1: next St=ERROR, MemTimeout<=1.
  - Otherwise WaitCnt<=WaitCnt+1.
- Taken (not overridden by a stall):
  - PCSrc=1, PCWrite=1.
  - IFIDFlush=IDEXFlush=EXMEMFlush=1.
  - Load-use is suppressed (the dependent instruction is squashed).
- LoadUse (no stall, no Taken):
  - PCWrite=0, IFIDWrite=0, IDEXFlush=1.
  - Other enables 1. Lasts exactly one cycle per hazard occurrence.
- ERROR:
  - All *Write=0, MEMWBFlush=1, MemReq=0, PCSrc=0.
  - Held until Rst_n=0. MemTimeout stays 1 until reset.
- StallCount increments by 1 on every clock edge where PCWrite=0, St!=ERROR and Rst_n=1. It saturates at 2^CNT_W-1 with no wrap.
- Reset asserted mid-MEM_WAIT: immediate return to reset values. The pending access is abandoned and MemReq drops asynchronously.
- Access and MemBranch asserted together is illegal per the ISA. The block handles it anyway: the access completes first, and the branch is applied on the release cycle.

Test Plan:
1. Load-use: ExMemRead=1, ExRt=8, IdRs=8 -> exactly one cycle of PCWrite=0, IFIDWrite=0, IDEXFlush=1; StallCount 0->1. Repeat with ExRt=0 -> no stall.
2. Taken branch: MemBranch=1, MemZero=1, with a simultaneous load-use on IdRt (IdUsesRt=1) -> PCSrc=1, three flushes=1, PCWrite=1, StallCount unchanged.
3. Zero-wait access: MemMemRead=1, MemReady=1 same cycle -> MemReq=1, no freeze, St stays RUN.
4. Wait states: MemMemWrite=1, MemReady low for 3 cycles then high -> 3 frozen cycles with MEMWBFlush=1, release on the 4th cycle, StallCount=3, back to RUN.
5. Timeout: MEM_TIMEOUT=16, MemReady held 0 -> ERROR entered on the 16th edge after the request, MemTimeout=1, all enables 0, held until reset; Rst_n pulse -> MemTimeout=0, StallCount=0.
6. Async reset mid-MEM_WAIT (between edges) -> outputs take reset values immediately. After release with no events, all *Write=1 on the first edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for a 5-stage pipeline. It replaces
// free-running stage registers with gated write enables and clear-to-bubble
// flushes. It handles three cases:
//   - load-use hazards between EX and ID,
//   - taken branches resolved in MEM,
//   - multi-cycle data-memory accesses, with a timeout trap.
//
// Ports
//   Clk, Rst_n        : clock (rising edge) and async active-low reset
//   IdRs/IdRt/IdUsesRt: source specifiers of the instruction in IF/ID
//   ExMemRead/ExRt    : load in EX and its destination register
//   MemBranch/MemZero : branch resolution in EX/MEM
//   MemMemRead/Write  : data-memory access in EX/MEM
//   MemReady          : data memory acknowledges the current access
//   *Write / *Flush   : stage-register enables and clear-to-bubble controls
//   PCSrc             : select branch target for the PC
//   MemReq            : data-memory request strobe
//   MemTimeout        : sticky error flag, cleared only by reset
//   StallCount        : saturating count of cycles with PCWrite=0
//   DbgState          : current sequencer state (0=RUN, 1=MEM_WAIT, 2=ERROR)
//
// Memory handshake: MemReq acts as valid and MemReady as ready. An access
// completes in the cycle where both are high. MemReq stays high until that
// cycle, the timeout, or reset. MemReady is ignored while MemReq is low.

module pipeline_hazard_ctrl #(
   parameter int REG_W       = 5,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [REG_W-1:0] IdRs,
   input  logic [REG_W-1:0] IdRt,
   input  logic             IdUsesRt,
   input  logic             ExMemRead,
   input  logic [REG_W-1:0] ExRt,
   input  logic             MemBranch,
   input  logic             MemZero,
   input  logic             MemMemRead,
   input  logic             MemMemWrite,
   input  logic             MemReady,
   output logic             PCWrite,
   output logic             PCSrc,
   output logic             IFIDWrite,
   output logic             IFIDFlush,
   output logic             IDEXWrite,
   output logic             IDEXFlush,
   output logic             EXMEMWrite,
   output logic             EXMEMFlush,
   output logic             MEMWBFlush,
   output logic             MemReq,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCount,
   output logic [1:0]       DbgState
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } state_e;

   localparam int WAIT_W = $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   state_e            st_q, st_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic access, taken, load_use;

   assign access   = MemMemRead | MemMemWrite;
   assign taken    = MemBranch & MemZero;
   // Register 0 is hard-wired, so a load into it never creates a hazard.
   assign load_use = ExMemRead && (ExRt != '0) &&
                     ((ExRt == IdRs) || (IdUsesRt && (ExRt == IdRt)));

   always_comb begin
      st_d        = st_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      PCWrite     = 1'b1;
      PCSrc       = 1'b0;
      IFIDWrite   = 1'b1;
      IFIDFlush   = 1'b0;
      IDEXWrite   = 1'b1;
      IDEXFlush   = 1'b0;
      EXMEMWrite  = 1'b1;
      EXMEMFlush  = 1'b0;
      MEMWBFlush  = 1'b0;
      MemReq      = 1'b0;

      unique case (st_q)
         ST_RUN, ST_MEM_WAIT: begin
            // A pending access always blocks the lower-priority events.
            // The release cycle falls through to branch/load-use evaluation.
            if (access || st_q == ST_MEM_WAIT) begin
               MemReq = 1'b1;
            end
            if (MemReq && !MemReady) begin
               PCWrite    = 1'b0;
               IFIDWrite  = 1'b0;
               IDEXWrite  = 1'b0;
               EXMEMWrite = 1'b0;
               MEMWBFlush = 1'b1;
               if (st_q == ST_RUN) begin
                  st_d       = ST_MEM_WAIT;
                  wait_cnt_d = WAIT_ONE;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  st_d      = ST_ERROR;
                  timeout_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_ONE;
               end
            end else begin
               st_d       = ST_RUN;
               wait_cnt_d = '0;
               if (taken) begin
                  // The dependent instruction is squashed, so load-use is moot.
                  PCSrc      = 1'b1;
                  IFIDFlush  = 1'b1;
                  IDEXFlush  = 1'b1;
                  EXMEMFlush = 1'b1;
               end else if (load_use) begin
                  PCWrite   = 1'b0;
                  IFIDWrite = 1'b0;
                  IDEXFlush = 1'b1;
               end
            end
         end
         ST_ERROR: begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
            MEMWBFlush = 1'b1;
         end
         default: begin
            st_d = ST_ERROR;
         end
      endcase

      // Reset overrides the decode combinationally, so an abandoned
      // access drops MemReq without waiting for a clock edge.
      if (!Rst_n) begin
         PCWrite    = 1'b0;
         PCSrc      = 1'b0;
         IFIDWrite  = 1'b0;
         IFIDFlush  = 1'b1;
         IDEXWrite  = 1'b0;
         IDEXFlush  = 1'b1;
         EXMEMWrite = 1'b0;
         EXMEMFlush = 1'b1;
         MEMWBFlush = 1'b1;
         MemReq     = 1'b0;
      end

      // Cycles frozen by the error trap are not counted as stalls.
      stall_cnt_d = stall_cnt_q;
      if (!PCWrite && st_q != ST_ERROR && stall_cnt_q != CNT_MAX) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         st_q        <= ST_RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         st_q        <= st_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign MemTimeout = timeout_q;
   assign StallCount = stall_cnt_q;
   assign DbgState   = st_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Control outputs are packed MSB first as:
//   {PCWrite, PCSrc, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
//    EXMEMWrite, EXMEMFlush, MEMWBFlush, MemReq}

module tb_pipeline_hazard_ctrl;

   localparam logic [9:0] C_RESET   = 10'b0001010110;
   localparam logic [9:0] C_IDLE    = 10'b1010101000;
   localparam logic [9:0] C_LDUSE   = 10'b0000111000;
   localparam logic [9:0] C_TAKEN   = 10'b1111111100;
   localparam logic [9:0] C_FREEZE  = 10'b0000000011;
   localparam logic [9:0] C_REQRUN  = 10'b1010101001;
   localparam logic [9:0] C_RELTAKE = 10'b1111111101;
   localparam logic [9:0] C_ERROR   = 10'b0000000010;

   logic       Clk, Rst_n;
   logic [4:0] IdRs, IdRt, ExRt;
   logic       IdUsesRt, ExMemRead, MemBranch, MemZero;
   logic       MemMemRead, MemMemWrite, MemReady;
   logic       PCWrite, PCSrc, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush;
   logic       EXMEMWrite, EXMEMFlush, MEMWBFlush, MemReq, MemTimeout;
   logic [15:0] StallCount;
   logic [1:0]  DbgState;

   int n_vec = 0;
   int n_err = 0;

   pipeline_hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(16), .CNT_W(16)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .IdRs(IdRs), .IdRt(IdRt), .IdUsesRt(IdUsesRt),
      .ExMemRead(ExMemRead), .ExRt(ExRt),
      .MemBranch(MemBranch), .MemZero(MemZero),
      .MemMemRead(MemMemRead), .MemMemWrite(MemMemWrite), .MemReady(MemReady),
      .PCWrite(PCWrite), .PCSrc(PCSrc),
      .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
      .IDEXWrite(IDEXWrite), .IDEXFlush(IDEXFlush),
      .EXMEMWrite(EXMEMWrite), .EXMEMFlush(EXMEMFlush),
      .MEMWBFlush(MEMWBFlush), .MemReq(MemReq),
      .MemTimeout(MemTimeout), .StallCount(StallCount), .DbgState(DbgState)
   );

   // Clock: period 10, rising edges at 5, 15, 25, ...
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      IdRs = '0; IdRt = '0; ExRt = '0;
      IdUsesRt = 1'b0; ExMemRead = 1'b0; MemBranch = 1'b0; MemZero = 1'b0;
      MemMemRead = 1'b0; MemMemWrite = 1'b0; MemReady = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [9:0] exp);
      logic [9:0] obs;
      obs = {PCWrite, PCSrc, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
             EXMEMWrite, EXMEMFlush, MEMWBFlush, MemReq};
      chk(tag, 32'(obs), 32'(exp));
   endtask

   initial begin
      idle_inputs();
      Rst_n = 1'b0;

      // Reset state, held across the first edge
      #7;
      chk_ctl("reset_ctl", C_RESET);
      chk("reset_stall", 32'(StallCount), 32'd0);
      chk("reset_timeout", 32'(MemTimeout), 32'd0);
      chk("reset_state", 32'(DbgState), 32'd0);
      #5 Rst_n = 1'b1;
      #1 chk_ctl("run_idle", C_IDLE);
      tick();
      chk("idle_stall", 32'(StallCount), 32'd0);

      // Load-use on rs: one stall cycle
      ExMemRead = 1'b1; ExRt = 5'd8; IdRs = 5'd8;
      #1 chk_ctl("lduse_rs_ctl", C_LDUSE);
      tick();
      chk("lduse_rs_stall", 32'(StallCount), 32'd1);
      ExMemRead = 1'b0;
      #1 chk_ctl("lduse_cleared", C_IDLE);
      tick();
      chk("lduse_no_extra", 32'(StallCount), 32'd1);

      // Load into register 0 never stalls
      ExMemRead = 1'b1; ExRt = 5'd0; IdRs = 5'd0;
      #1 chk_ctl("lduse_r0_ctl", C_IDLE);
      tick();
      chk("lduse_r0_stall", 32'(StallCount), 32'd1);

      // rt match counts only if the instruction reads rt
      ExRt = 5'd5; IdRt = 5'd5; IdRs = 5'd3; IdUsesRt = 1'b0;
      #1 chk_ctl("lduse_rt_unused", C_IDLE);
      IdUsesRt = 1'b1;
      #1 chk_ctl("lduse_rt_used", C_LDUSE);
      tick();
      chk("lduse_rt_stall", 32'(StallCount), 32'd2);

      // Taken branch overrides a simultaneous load-use on rt
      idle_inputs();
      ExMemRead = 1'b1; ExRt = 5'd7; IdRt = 5'd7; IdUsesRt = 1'b1; IdRs = 5'd1;
      MemBranch = 1'b1; MemZero = 1'b1;
      #1 chk_ctl("taken_ctl", C_TAKEN);
      tick();
      chk("taken_stall", 32'(StallCount), 32'd2);
      MemZero = 1'b0;
      #1 chk_ctl("not_taken_lduse", C_LDUSE);
      ExMemRead = 1'b0;
      #1 chk_ctl("not_taken_idle", C_IDLE);
      tick();
      chk("not_taken_stall", 32'(StallCount), 32'd2);

      // Zero-wait access
      idle_inputs();
      MemMemRead = 1'b1; MemReady = 1'b1;
      #1 chk_ctl("zw_ctl", C_REQRUN);
      tick();
      chk("zw_state", 32'(DbgState), 32'd0);
      chk("zw_stall", 32'(StallCount), 32'd2);

      // Three wait states, release on the fourth cycle
      idle_inputs();
      MemMemWrite = 1'b1;
      #1 chk_ctl("ws0_ctl", C_FREEZE);
      chk("ws0_state", 32'(DbgState), 32'd0);
      tick();
      chk_ctl("ws1_ctl", C_FREEZE);
      chk("ws1_state", 32'(DbgState), 32'd1);
      tick();
      chk_ctl("ws2_ctl", C_FREEZE);
      tick();
      chk("ws3_stall", 32'(StallCount), 32'd5);
      MemReady = 1'b1;
      #1 chk_ctl("ws_release_ctl", C_REQRUN);
      tick();
      chk("ws_back_run", 32'(DbgState), 32'd0);
      chk("ws_final_stall", 32'(StallCount), 32'd5);

      // Access and taken branch together: access first, branch on release
      idle_inputs();
      MemMemRead = 1'b1; MemBranch = 1'b1; MemZero = 1'b1;
      #1 chk_ctl("acc_br_freeze", C_FREEZE);
      tick();
      chk("acc_br_state", 32'(DbgState), 32'd1);
      MemReady = 1'b1;
      #1 chk_ctl("acc_br_release", C_RELTAKE);
      tick();
      chk("acc_br_stall", 32'(StallCount), 32'd6);
      chk("acc_br_run", 32'(DbgState), 32'd0);

      // Timeout: ERROR on the 16th edge after the request
      idle_inputs();
      MemMemRead = 1'b1;
      #1 chk_ctl("to_req_ctl", C_FREEZE);
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk($sformatf("to_wait_%0d", i), 32'(DbgState), 32'd1);
      end
      chk("to_flag_pre", 32'(MemTimeout), 32'd0);
      tick();
      chk("to_state", 32'(DbgState), 32'd2);
      chk("to_flag", 32'(MemTimeout), 32'd1);
      chk_ctl("to_ctl", C_ERROR);
      chk("to_stall", 32'(StallCount), 32'd22);
      MemReady = 1'b1;
      tick();
      tick();
      chk_ctl("err_hold_ctl", C_ERROR);
      chk("err_hold_state", 32'(DbgState), 32'd2);
      chk("err_hold_flag", 32'(MemTimeout), 32'd1);
      chk("err_hold_stall", 32'(StallCount), 32'd22);
      #2 Rst_n = 1'b0;
      #1 chk_ctl("err_rst_ctl", C_RESET);
      chk("err_rst_flag", 32'(MemTimeout), 32'd0);
      chk("err_rst_stall", 32'(StallCount), 32'd0);
      chk("err_rst_state", 32'(DbgState), 32'd0);
      idle_inputs();
      #1 Rst_n = 1'b1;
      #1 chk_ctl("err_rel_ctl", C_IDLE);
      tick();
      chk("err_rel_stall", 32'(StallCount), 32'd0);

      // Async reset between edges in MEM_WAIT
      MemMemWrite = 1'b1;
      tick();
      tick();
      chk("mw_state", 32'(DbgState), 32'd1);
      chk("mw_stall", 32'(StallCount), 32'd2);
      #3 Rst_n = 1'b0;
      #1 chk_ctl("mw_rst_ctl", C_RESET);
      chk("mw_rst_state", 32'(DbgState), 32'd0);
      chk("mw_rst_stall", 32'(StallCount), 32'd0);
      idle_inputs();
      #1 Rst_n = 1'b1;
      tick();
      chk_ctl("mw_rel_ctl", C_IDLE);
      chk("mw_rel_stall", 32'(StallCount), 32'd0);
      chk("mw_rel_state", 32'(DbgState), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
